// File: rtl/sm_sfu_pkg.sv
// Shared types and constants for the SFU warp dispatcher.
package sm_sfu_pkg;

  localparam int unsigned SFU_WORD_W = 32;
  localparam logic [SFU_WORD_W-1:0] SFU_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } sfu_state_e;

  // Index width that stays legal for a single-entry range.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfu_lane_pick.sv
// Lowest-index pending lane selector for the SFU dispatcher.
module sfu_lane_pick #(
  parameter int unsigned LANES = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [LANES-1:0] pend_i,
  output logic [IDX_W-1:0] lane_idx_c_o,
  output logic             any_pend_c_o
);

  logic found;

  always_comb begin
    lane_idx_c_o = '0;
    found        = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (pend_i[i] && !found) begin
        lane_idx_c_o = IDX_W'(i);
        found        = 1'b1;
      end
    end
  end

  assign any_pend_c_o = |pend_i;

endmodule

// File: rtl/sfu_dispatch.sv
// SFU warp dispatcher: serialises the active lanes of one warp through a single
// SFU and returns the gathered result vector. SFU_DISPATCH_TIMEOUT_EN adds a response watchdog.
module sfu_dispatch
  import sm_sfu_pkg::*;
#(
  parameter int unsigned LANES       = 8,
  parameter int unsigned WARP_ID_W   = 5,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [WARP_ID_W-1:0]        req_warp,
  input  logic [LANES-1:0]            req_mask,
  input  logic [LANES*SFU_WORD_W-1:0] req_data,
  output logic                        sfu_start,
  output logic [SFU_WORD_W-1:0]       sfu_in,
  input  logic [SFU_WORD_W-1:0]       sfu_out,
  input  logic                        sfu_ready,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [WARP_ID_W-1:0]        wb_warp,
  output logic [LANES-1:0]            wb_mask,
  output logic [LANES*SFU_WORD_W-1:0] wb_data,
  output logic                        busy,
  output logic                        err_timeout
);

  localparam int unsigned IDX_W = idx_width(LANES);
  localparam int unsigned WD_W  = idx_width(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

`ifdef SFU_DISPATCH_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  sfu_state_e state_q, state_d;

  logic [LANES-1:0]                 pend_q, pend_d;
  logic [LANES-1:0]                 mask_q, mask_d;
  logic [WARP_ID_W-1:0]             warp_q, warp_d;
  logic [LANES-1:0][SFU_WORD_W-1:0] lane_q, lane_d;
  logic [IDX_W-1:0]                 sel_q, sel_d;
  logic [WD_W-1:0]                  wd_q, wd_d;
  logic                             err_q, err_d;
  logic                             start_q, start_d;
  logic [SFU_WORD_W-1:0]            sfu_in_q, sfu_in_d;
  logic                             req_ready_q, busy_q, wb_valid_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             timeout_hit;

  assign timeout_hit = TIMEOUT_EN & (wd_q == WD_LAST);

  // Next-state and lane-buffer update; the buffer holds operands until each is overwritten by its result.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mask_d  = mask_q;
    warp_d  = warp_q;
    lane_d  = lane_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          warp_d = req_warp;
          mask_d = req_mask;
          pend_d = req_mask;
          err_d  = 1'b0;
          for (int i = 0; i < int'(LANES); i++) begin
            lane_d[i] = req_mask[i] ? req_data[i*SFU_WORD_W +: SFU_WORD_W] : '0;
          end
          state_d = (req_mask != '0) ? ISSUE : WB;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (sfu_ready || timeout_hit) begin
          lane_d[sel_q] = sfu_ready ? sfu_out : SFU_NAN;
          pend_d[sel_q] = 1'b0;
          err_d         = err_q | ~sfu_ready;
          state_d       = (pend_d != '0) ? ISSUE : WB;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      WB: begin
        if (wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sfu_lane_pick #(
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_pick (
    .pend_i       (pend_d),
    .lane_idx_c_o (pick_idx),
    .any_pend_c_o (pick_any)
  );

  // Issue decision is taken on the post-update pending set so the start pulse lands in ISSUE.
  always_comb begin
    start_d  = (state_d == ISSUE) && pick_any;
    sel_d    = sel_q;
    sfu_in_d = '0;
    if (start_d) begin
      sel_d    = pick_idx;
      sfu_in_d = lane_d[pick_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      mask_q      <= '0;
      warp_q      <= '0;
      lane_q      <= '0;
      sel_q       <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      sfu_in_q    <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      warp_q      <= warp_d;
      lane_q      <= lane_d;
      sel_q       <= sel_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      start_q     <= start_d;
      sfu_in_q    <= sfu_in_d;
      req_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      wb_valid_q  <= (state_d == WB);
    end
  end

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign sfu_start   = start_q;
  assign sfu_in      = sfu_in_q;
  assign wb_valid    = wb_valid_q;
  assign wb_warp     = warp_q;
  assign wb_mask     = mask_q;
  assign wb_data     = lane_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_sfu_dispatch.sv
// Self-checking bench for sfu_dispatch: directed table, randomized warps, stall and reset corners.
`timescale 1ns/1ps
module tb_sfu_dispatch;

  localparam int unsigned LANES  = 8;
  localparam int unsigned WID    = 5;
  localparam int unsigned TO     = 64;
  localparam int unsigned DW     = LANES * 32;
  localparam int          BUDGET = 400;
  localparam int          HANG   = 150;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [WID-1:0] req_warp;
  logic [LANES-1:0] req_mask;
  logic [DW-1:0]  req_data;
  logic           sfu_start;
  logic [31:0]    sfu_in;
  logic [31:0]    sfu_out;
  logic           sfu_ready;
  logic           wb_valid;
  logic           wb_ready;
  logic [WID-1:0] wb_warp;
  logic [LANES-1:0] wb_mask;
  logic [DW-1:0]  wb_data;
  logic           busy;
  logic           err_timeout;

  always #5 clk = ~clk;

  sfu_dispatch #(
    .LANES       (LANES),
    .WARP_ID_W   (WID),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_warp    (req_warp),
    .req_mask    (req_mask),
    .req_data    (req_data),
    .sfu_start   (sfu_start),
    .sfu_in      (sfu_in),
    .sfu_out     (sfu_out),
    .sfu_ready   (sfu_ready),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_warp     (wb_warp),
    .wb_mask     (wb_mask),
    .wb_data     (wb_data),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int rel   = 0;

  // SFU environment model: doubles its operand after lat cycles; drop_mask silences selected issues.
  int          due_q[$];
  logic [31:0] val_q[$];
  logic [31:0] start_log[$];
  int          lat;
  bit          noise;
  bit [31:0]   drop_mask;
  int          start_cnt;

  typedef struct {
    logic [WID-1:0]   warp;
    logic [LANES-1:0] mask;
    logic [DW-1:0]    data;
    int               lat;
    int               hold;
    bit               noise;
    logic [DW-1:0]    exp_data;
    int               exp_rel;
    int               exp_starts;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sfu_ready = 1'b0;
    sfu_out   = $urandom;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      sfu_ready = 1'b1;
      sfu_out   = val_q[0];
      void'(due_q.pop_front());
      void'(val_q.pop_front());
    end else if (noise && (sfu_start || wb_valid || !busy) && $urandom_range(1, 0) == 1) begin
      sfu_ready = 1'b1;
    end
    if (sfu_start === 1'b1) begin
      start_log.push_back(sfu_in);
      if (!drop_mask[start_cnt]) begin
        due_q.push_back(cyc + lat);
        val_q.push_back(32'(sfu_in << 1));
      end
      start_cnt++;
    end
  endtask

  // Reference: each active lane's operand doubled, inactive lanes zero.
  function automatic logic [DW-1:0] ref_wb(input logic [LANES-1:0] m, input logic [DW-1:0] d);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < int'(LANES); i++)
      if (m[i]) r[32*i +: 32] = 32'(d[32*i +: 32] * 2);
    return r;
  endfunction

  function automatic logic [DW-1:0] seq_data(input int base);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(LANES); i++) r[32*i +: 32] = 32'(base + i);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < int'(LANES); i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic launch(input logic [WID-1:0] w, input logic [LANES-1:0] m, input logic [DW-1:0] d,
                        input int l, input bit nz, input bit [31:0] dm);
    lat       = l;
    noise     = nz;
    drop_mask = dm;
    start_cnt = 0;
    start_log.delete();
    req_valid = 1'b1;
    req_warp  = w;
    req_mask  = m;
    req_data  = d;
    tick();
    req_valid = 1'b0;
    req_warp  = WID'($urandom);
    req_mask  = LANES'($urandom);
    req_data  = rand_data();
    rel       = 1;
  endtask

  task automatic finish(input string tag, input logic [WID-1:0] w, input logic [LANES-1:0] m,
                        input logic [DW-1:0] d, input int hold, input logic [DW-1:0] exp_data,
                        input int exp_rel, input int exp_starts);
    bit seen = 1'b0;
    bit ok = 1'b1;
    bit stable = 1'b1;
    bit ord_ok;
    logic [DW-1:0] snap;
    logic [31:0] exp_ops[$];
    while (!seen && rel <= BUDGET) begin
      if (wb_valid === 1'b1) seen = 1'b1;
      else begin
        if (req_ready !== 1'b0 || busy !== 1'b1 || (sfu_start !== 1'b1 && sfu_in !== 32'h0)) ok = 1'b0;
        tick();
        rel++;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s/wb_wait: wb_valid low after %0d cycles, required high", tag, BUDGET);
    end
    chk({tag, "/wb_cycle"}, DW'(rel), DW'(exp_rel));
    chk({tag, "/wb_data"}, wb_data, exp_data);
    chk({tag, "/wb_tag"}, DW'({wb_warp, wb_mask}), DW'({w, m}));
    chk({tag, "/busy_phase"}, DW'(ok), DW'(1));
    snap = wb_data;
    for (int h = 0; h < hold; h++) begin
      tick();
      rel++;
      if (wb_valid !== 1'b1 || wb_data !== snap || wb_warp !== w || wb_mask !== m ||
          req_ready !== 1'b0 || busy !== 1'b1 || sfu_start !== 1'b0) stable = 1'b0;
    end
    chk({tag, "/wb_hold"}, DW'(stable), DW'(1));
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk({tag, "/handshake"}, DW'({wb_valid, req_ready, busy}), DW'(3'b010));
    chk({tag, "/starts"}, DW'(start_cnt), DW'(exp_starts));
    for (int i = 0; i < int'(LANES); i++)
      if (m[i]) exp_ops.push_back(d[32*i +: 32]);
    ord_ok = (start_log.size() == exp_ops.size());
    for (int i = 0; i < exp_ops.size() && ord_ok; i++)
      if (start_log[i] !== exp_ops[i]) ord_ok = 1'b0;
    chk({tag, "/issue_order"}, DW'(ord_ok), DW'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    bit            quiet;
    int            n;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_warp  = '0;
    req_mask  = '0;
    req_data  = '0;
    wb_ready  = 1'b0;
    sfu_ready = 1'b0;
    sfu_out   = '0;
    lat       = 1;
    noise     = 1'b0;
    drop_mask = '0;
    start_cnt = 0;

    vecs[0] = '{5'h03, 8'hFF, seq_data(1), 1, 0, 1'b0,
                {32'd16, 32'd14, 32'd12, 32'd10, 32'd8, 32'd6, 32'd4, 32'd2}, 17, 8};
    vecs[1] = '{5'h1F, 8'h00, seq_data(40), 1, 2, 1'b0, '0, 1, 0};
    vecs[2] = '{5'h0A, 8'hA5, seq_data(100), 1, 10, 1'b0,
                {32'd214, 32'd0, 32'd210, 32'd0, 32'd0, 32'd204, 32'd0, 32'd200}, 9, 4};
    vecs[3] = '{5'h11, 8'h80, seq_data(1), 3, 1, 1'b1, {32'd16, 224'd0}, 5, 1};
    vecs[4] = '{5'h01, 8'h01, seq_data(1), 2, 3, 1'b1, {224'd0, 32'd2}, 4, 1};

    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("reset/ready", DW'(req_ready), DW'(1));
    chk("reset/ctl", DW'({busy, wb_valid, sfu_start, sfu_in, err_timeout, wb_warp, wb_mask}), '0);
    chk("reset/data", wb_data, '0);
    tick();

    for (int i = 0; i < 5; i++) begin
      launch(vecs[i].warp, vecs[i].mask, vecs[i].data, vecs[i].lat, vecs[i].noise, '0);
      finish($sformatf("vec%0d", i), vecs[i].warp, vecs[i].mask, vecs[i].data, vecs[i].hold,
             vecs[i].exp_data, vecs[i].exp_rel, vecs[i].exp_starts);
    end

    for (int k = 0; k < 20; k++) begin
      logic [LANES-1:0] m;
      logic [WID-1:0]   w;
      int               l;
      int               h;
      bit               nz;
      m  = LANES'($urandom);
      if (k == 3) m = '0;
      if (k == 7) m = '1;
      w  = WID'($urandom);
      d  = rand_data();
      l  = $urandom_range(3, 1);
      h  = $urandom_range(3, 0);
      nz = 1'($urandom_range(1, 0));
      launch(w, m, d, l, nz, '0);
      finish($sformatf("rnd%0d", k), w, m, d, h, ref_wb(m, d),
             1 + $countones(m) * (l + 1), $countones(m));
    end

    d = rand_data();
`ifdef SFU_DISPATCH_TIMEOUT_EN
    e = '0;
    e[31:0]  = QNAN;
    e[63:32] = 32'(d[63:32] << 1);
    launch(5'h07, 8'h03, d, 1, 1'b0, 32'h1);
    finish("timeout", 5'h07, 8'h03, d, 0, e, 1 + (1 + int'(TO)) + 2, 2);
    chk("timeout/err_set", DW'(err_timeout), DW'(1));
    launch(5'h08, 8'h00, d, 1, 1'b0, '0);
    chk("timeout/err_clear", DW'(err_timeout), DW'(0));
    finish("after_to", 5'h08, 8'h00, d, 0, '0, 1, 0);
`else
    e = ref_wb(8'h03, d);
    launch(5'h07, 8'h03, d, 1, 1'b0, 32'h1);
    quiet = 1'b1;
    for (int i = 0; i < HANG; i++) begin
      tick();
      rel++;
      if (wb_valid !== 1'b0 || busy !== 1'b1 || err_timeout !== 1'b0) quiet = 1'b0;
    end
    chk("stall/holds", DW'({quiet, 8'(start_cnt)}), DW'({1'b1, 8'd1}));
    due_q.push_back(cyc + 1);
    val_q.push_back(32'(d[31:0] << 1));
    finish("stall", 5'h07, 8'h03, d, 0, e, HANG + 5, 2);
    chk("stall/err", DW'(err_timeout), DW'(0));
`endif

    d = seq_data(1);
    launch(5'h15, 8'hFF, d, 1, 1'b0, 32'hFFFF_FFF8);
    n = 0;
    while (start_cnt < 4 && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk("rst/in_wait", DW'({busy, sfu_start, wb_valid, 8'(start_cnt)}), DW'({3'b100, 8'd4}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst/sfu_outs", DW'({sfu_start, sfu_in}), '0);
    chk("rst/wb_outs", DW'({wb_valid, wb_warp, wb_mask, busy, err_timeout}), '0);
    chk("rst/wb_data", wb_data, '0);
    due_q.delete();
    val_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst/ready_after", DW'(req_ready), DW'(1));
    due_q.push_back(cyc + 1);
    val_q.push_back(32'hDEAD_BEEF);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wb_valid !== 1'b0 || busy !== 1'b0 || sfu_start !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
    end
    chk("rst/late_ready_ignored", DW'(quiet), DW'(1));
    chk("rst/data_clear", wb_data, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sfu_dispatch.md
SFU_DISPATCH -- requirements
Module: sfu_dispatch

Interface
REQ-001 SHALL have parameter LANES, default 8, giving lanes per warp request.
REQ-002 SHALL have parameter WARP_ID_W, default 5, giving the warp tag width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64, giving the SFU response watchdog limit in cycles.
REQ-004 Ports, clock and reset first:
  clk  in  1  clock
  rst_n  in  1  reset, asynchronous, active-low
  req_valid  in  1  warp request offered
  req_ready  out  1  dispatcher can accept a request
  req_warp  in  WARP_ID_W  warp tag
  req_mask  in  LANES  active-lane mask
  req_data  in  LANES*32  lane operands, lane i at bits [32i+31:32i]
  sfu_start  out  1  one-cycle issue pulse to the SFU
  sfu_in  out  32  operand to the SFU
  sfu_out  in  32  SFU result
  sfu_ready  in  1  SFU result valid
  wb_valid  out  1  result vector valid
  wb_ready  in  1  writeback sink accepts
  wb_warp  out  WARP_ID_W  echoed warp tag
  wb_mask  out  LANES  echoed mask
  wb_data  out  LANES*32  result vector
  busy  out  1  state is not IDLE
  err_timeout  out  1  sticky SFU timeout flag

Function
REQ-005 FSM states: IDLE, ISSUE, WAIT, WB.
REQ-006 IDLE: req_ready=1; on req_valid&&req_ready, capture warp, mask and data.
  - Go to ISSUE if mask!=0.
  - Go to WB if mask==0.
REQ-007 req_ready SHALL be 0 in every state except IDLE; there is no overlap of requests.
REQ-008 Pending set initialised to req_mask on acceptance; ISSUE selects the lowest-index pending lane.
REQ-009 ISSUE lasts exactly one cycle: sfu_start=1, sfu_in=selected lane operand; then go to WAIT.
REQ-010 sfu_start SHALL be 0 in all other states; sfu_in SHALL be 0 when sfu_start=0.
REQ-011 WAIT: on sfu_ready=1, write sfu_out into the selected lane slot and clear its pending bit.
  - Go to ISSUE if any lane is still pending, else go to WB.
REQ-012 sfu_ready SHALL be ignored outside WAIT; a ready in the same cycle as sfu_start is ignored.
REQ-013 Inactive lanes' wb_data slots SHALL be 32'h0.
REQ-014 Timing: with acceptance at edge T and N active lanes (N>=1):
  - start pulses occur at cycles T+1, T+3, ... T+2N-1 when the SFU answers in one cycle.
  - wb_valid is first asserted at cycle T+1+2N.
  - For mask==0, wb_valid is asserted at T+1.
REQ-015 WB: wb_valid=1 with wb_warp/wb_mask/wb_data stable until wb_ready=1; on the handshake edge go to IDLE.
REQ-016 wb_valid=1 and wb_ready=1 in the same cycle completes WB; a new request can be accepted no earlier than the next cycle.
REQ-017 busy = (state != IDLE).

Reset
REQ-018 Asynchronous assertion of rst_n SHALL force:
  - state IDLE;
  - pending, lane buffer, wb_* and sfu_* outputs to 0;
  - err_timeout to 0;
  - watchdog counter to 0.
REQ-019 Reset mid-operation SHALL discard the in-flight warp with no wb_valid pulse; any later sfu_ready is ignored.
REQ-020 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-021 Macro SFU_DISPATCH_TIMEOUT_EN compiled in:
  - WAIT counts cycles.
  - After TIMEOUT_CYC cycles without sfu_ready, the lane result is 32'h7FC00000 (qNaN), the lane is cleared as if answered, and err_timeout is set.
  - err_timeout stays set until the next request acceptance clears it.
REQ-022 Macro absent: WAIT waits indefinitely; err_timeout is tied to 0; port list is unchanged.

Structure
REQ-023 Shared package sm_sfu_pkg SHALL hold:
  - the state enum typedef (IDLE/ISSUE/WAIT/WB);
  - the SFU_NAN constant 32'h7FC00000;
  - the lane word width constant (32).
REQ-024 One sub-module, sfu_lane_pick, SHALL be a combinational lowest-set-bit priority encoder over the pending mask, giving lane index and any-pending.

Verification
REQ-025 mask=8'hFF, operands 1..8, SFU model doubles input with one-cycle latency -> 8 start pulses two cycles apart; wb_data lanes 2..16; wb_valid at T+17.
REQ-026 mask=8'h00 -> no sfu_start; wb_valid at T+1; wb_data all zero; warp tag echoed.
REQ-027 mask=8'hA5 with wb_ready held low 10 cycles -> lanes 0,2,5,7 issued in that order; other slots 0; outputs stable until wb_ready=1; req_ready=0 throughout.
REQ-028 Reset asserted in WAIT of lane 3 -> outputs 0 immediately; a later sfu_ready is ignored; req_ready=1 after release; no wb_valid.
REQ-029 SFU_DISPATCH_TIMEOUT_EN on, TIMEOUT_CYC=64, SFU never answers lane 0 of mask 8'h03 -> lane 0 result 32'h7FC00000; err_timeout=1; lane 1 still issued; flag cleared on the next acceptance.
